// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM command codes, state encoding, defaults and classification helpers
package pwm_pkg;

  localparam int DEFAULT_PERIOD = 50_000;
  localparam int DEFAULT_TOL    = 500;
  localparam int CNT_W          = 17;

  localparam logic [7:0] CODE_ZERO  = 8'h30;
  localparam logic [7:0] CODE_FORTY = 8'h63;
  localparam logic [7:0] CODE_FULL  = 8'h78;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STEADY  = 2'd2
  } pwm_state_e;

  typedef enum logic [1:0] {
    CNT_INC   = 2'd0,
    CNT_START = 2'd1,
    CNT_CLEAR = 2'd2
  } cnt_op_e;

  typedef struct packed {
    logic       ok;
    logic [7:0] code;
  } pwm_class_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  function automatic logic [17:0] abs18(input logic signed [17:0] v);
    return (v < 0) ? 18'(-v) : 18'(v);
  endfunction

  // 18-bit signed math so that short periods never wrap when compared against nominal
  function automatic pwm_class_t classify(input logic [CNT_W-1:0] period,
                                          input logic [CNT_W-1:0] high,
                                          input int nom, input int tol);
    logic signed [17:0] p_s, h_s, nom_s, tol_s, forty_s, full_lo_s;
    logic [17:0]        tol_u;
    pwm_class_t         res;
    p_s       = $signed({1'b0, period});
    h_s       = $signed({1'b0, high});
    nom_s     = 18'(nom);
    tol_s     = 18'(tol);
    tol_u     = 18'(tol);
    forty_s   = 18'((2 * nom) / 5);
    full_lo_s = 18'(nom - tol);
    res = '{ok: 1'b0, code: CODE_ZERO};
    if (abs18(p_s - nom_s) <= tol_u) begin
      if (h_s <= tol_s) begin
        res = '{ok: 1'b1, code: CODE_ZERO};
      end else if (abs18(h_s - forty_s) <= tol_u) begin
        res = '{ok: 1'b1, code: CODE_FORTY};
      end else if (h_s >= full_lo_s) begin
        res = '{ok: 1'b1, code: CODE_FULL};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer plus edge-detect flop
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/pwm_decode.sv
// rtl/pwm_decode.sv - measures a remote PWM line and decodes its duty into a command byte
module pwm_decode
  import pwm_pkg::*;
#(
  parameter int PERIOD = DEFAULT_PERIOD,
  parameter int TOL    = DEFAULT_TOL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [7:0]  code,
  output logic        code_valid,
  output logic        code_chg,
  output logic [16:0] duty,
  output logic        err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] PERIOD_CNT  = CNT_W'(PERIOD);

  logic             level, rise, fall;
  pwm_state_e       state, state_next;
  cnt_op_e          cnt_op;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             emit, err_set;
  logic [7:0]       emit_code;
  logic [16:0]      emit_duty;
  pwm_class_t       cls;
  logic [7:0]       level_code;
  logic [16:0]      level_duty;

  sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign level_code = level ? CODE_FULL : CODE_ZERO;
  assign level_duty = level ? PERIOD_CNT : '0;
  assign cls        = classify(period_cnt, high_cnt, PERIOD, TOL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_op     = CNT_INC;
    emit       = 1'b0;
    emit_code  = code;
    emit_duty  = duty;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_MEASURE;
          cnt_op     = CNT_START;
        end else if (period_cnt >= TIMEOUT_CNT) begin
          state_next = ST_STEADY;
          cnt_op     = CNT_START;
          emit       = 1'b1;
          emit_code  = level_code;
          emit_duty  = level_duty;
        end
      end
      ST_MEASURE: begin
        // The rise cycle is the first cycle of the next period, so counters restart at it
        if (rise) begin
          cnt_op = CNT_START;
          if (cls.ok) begin
            emit      = 1'b1;
            emit_code = cls.code;
            emit_duty = high_cnt;
          end else begin
            err_set = 1'b1;
          end
        end else if (period_cnt >= TIMEOUT_CNT) begin
          state_next = ST_STEADY;
          cnt_op     = CNT_START;
          emit       = 1'b1;
          emit_code  = level_code;
          emit_duty  = level_duty;
        end
      end
      ST_STEADY: begin
        if (rise) begin
          state_next = ST_MEASURE;
          cnt_op     = CNT_START;
        end else if (fall) begin
          state_next = ST_IDLE;
          cnt_op     = CNT_CLEAR;
        end else if (period_cnt >= PERIOD_CNT) begin
          cnt_op    = CNT_START;
          emit      = 1'b1;
          emit_code = level_code;
          emit_duty = level_duty;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_op     = CNT_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else begin
      case (cnt_op)
        CNT_START: begin
          period_cnt <= CNT_W'(1);
          high_cnt   <= {{(CNT_W-1){1'b0}}, level};
        end
        CNT_CLEAR: begin
          period_cnt <= '0;
          high_cnt   <= '0;
        end
        default: begin
          period_cnt <= sat_inc(period_cnt, 1'b1);
          high_cnt   <= sat_inc(high_cnt, level);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= CODE_ZERO;
      duty       <= '0;
      code_valid <= 1'b0;
      code_chg   <= 1'b0;
      err        <= 1'b0;
    end else begin
      code_valid <= emit;
      code_chg   <= emit && (emit_code != code);
      err        <= err_set;
      if (emit) begin
        code <= emit_code;
        duty <= emit_duty;
      end
    end
  end

endmodule

// File: tb/tb_pwm_decode.sv
// tb/tb_pwm_decode.sv - directed self-checking bench for pwm_decode (PERIOD=1000, TOL=10)
module tb_pwm_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [7:0]  code;
  logic        code_valid, code_chg, err;
  logic [16:0] duty;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_valid = 0, n_chg = 0, n_err = 0, n_viol = 0;
  int first_valid = -1, last_valid = -1;
  logic [16:0] prev_duty = '0;

  pwm_decode #(.PERIOD(1000), .TOL(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .code       (code),
    .code_valid (code_valid),
    .code_chg   (code_chg),
    .duty       (duty),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Event monitor on the falling edge; cyc counts rising edges since reset release
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else begin
      cyc++;
      if (code_valid) begin
        n_valid++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
      if (code_chg) n_chg++;
      if (err) n_err++;
      if ((err && (code_valid || code_chg)) || (code_chg && !code_valid)) n_viol++;
      if (!code_valid && (duty !== prev_duty)) n_viol++;
    end
    prev_duty = duty;
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    pwm_in = 1'b0;
    wait_cycles(3);
    n_valid = 0; n_chg = 0; n_err = 0;
    first_valid = -1; last_valid = -1;
    rst_n = 1'b1;
  endtask

  task automatic drive_period(input int hi, input int per);
    for (int i = 0; i < per; i++) begin
      pwm_in = (i < hi);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_counts(input string tag, input int ev, input int ec, input int ee,
                              input logic [7:0] ecode, input logic [16:0] eduty);
    n_checks++;
    if (n_valid !== ev) $display("FAIL %s valid_count got %0d want %0d", tag, n_valid, ev);
    else n_pass++;
    n_checks++;
    if (n_chg !== ec) $display("FAIL %s chg_count got %0d want %0d", tag, n_chg, ec);
    else n_pass++;
    n_checks++;
    if (n_err !== ee) $display("FAIL %s err_count got %0d want %0d", tag, n_err, ee);
    else n_pass++;
    n_checks++;
    if (code !== ecode) $display("FAIL %s code got %0h want %0h", tag, code, ecode);
    else n_pass++;
    n_checks++;
    if (duty !== eduty) $display("FAIL %s duty got %0d want %0d", tag, duty, eduty);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pwm_in = 1'b1;
    wait_cycles(4);
    n_checks++;
    if (code !== 8'h30) $display("FAIL reset_code got %0h want 30", code); else n_pass++;
    n_checks++;
    if (duty !== 17'd0) $display("FAIL reset_duty got %0d want 0", duty); else n_pass++;
    n_checks++;
    if (code_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", code_valid); else n_pass++;
    n_checks++;
    if (code_chg !== 1'b0) $display("FAIL reset_chg got %b want 0", code_chg); else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
  endtask

  task automatic test_forty();
    do_reset();
    for (int p = 0; p < 5; p++) drive_period(400, 1000);
    check_counts("forty", 4, 1, 0, 8'h63, 17'd400);
  endtask

  task automatic test_full();
    do_reset();
    pwm_in = 1'b1;
    wait_cycles(2500);
    check_counts("full", 2, 1, 0, 8'h78, 17'd1000);
    n_checks++;
    if (first_valid !== 1013) $display("FAIL full_first_valid got %0d want 1013", first_valid);
    else n_pass++;
    n_checks++;
    if (last_valid !== 2013) $display("FAIL full_reemit got %0d want 2013", last_valid);
    else n_pass++;
  endtask

  task automatic test_zero();
    do_reset();
    for (int p = 0; p < 5; p++) drive_period(1, 1000);
    check_counts("zero", 4, 0, 0, 8'h30, 17'd1);
  endtask

  task automatic test_bad_duty();
    do_reset();
    for (int p = 0; p < 3; p++) drive_period(400, 1000);
    for (int p = 0; p < 3; p++) drive_period(700, 1000);
    check_counts("bad_duty", 3, 1, 2, 8'h63, 17'd400);
  endtask

  task automatic test_period_tol();
    do_reset();
    for (int p = 0; p < 3; p++) drive_period(320, 800);
    for (int p = 0; p < 3; p++) drive_period(400, 1000);
    check_counts("period_tol", 2, 1, 3, 8'h63, 17'd400);
  endtask

  task automatic test_boundaries();
    do_reset();
    drive_period(400, 1000);
    drive_period(410, 1010);
    drive_period(390, 990);
    drive_period(400, 989);
    drive_period(400, 1000);
    check_counts("boundaries", 3, 1, 1, 8'h63, 17'd390);
  endtask

  task automatic test_reset_mid();
    do_reset();
    pwm_in = 1'b1;
    wait_cycles(1500);
    n_checks++;
    if (code !== 8'h78) $display("FAIL mid_pre_code got %0h want 78", code); else n_pass++;
    @(negedge clk);
    #1 rst_n = 1'b0;
    pwm_in = 1'b0;
    #1;
    n_checks++;
    if (code !== 8'h30) $display("FAIL mid_code got %0h want 30", code); else n_pass++;
    n_checks++;
    if (duty !== 17'd0) $display("FAIL mid_duty got %0d want 0", duty); else n_pass++;
    n_checks++;
    if ({code_valid, code_chg, err} !== 3'b000)
      $display("FAIL mid_pulses got %b want 000", {code_valid, code_chg, err});
    else n_pass++;
    wait_cycles(2);
    n_valid = 0; n_chg = 0; n_err = 0;
    first_valid = -1; last_valid = -1;
    rst_n = 1'b1;
    wait_cycles(1200);
    n_checks++;
    if (first_valid !== 1011) $display("FAIL mid_first_valid got %0d want 1011", first_valid);
    else n_pass++;
    check_counts("mid_after", 1, 0, 0, 8'h30, 17'd0);
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (n_viol !== 0) $display("FAIL exclusive_pulses got %0d violations want 0", n_viol);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_forty();
    test_full();
    test_zero();
    test_bad_duty();
    test_period_tol();
    test_boundaries();
    test_reset_mid();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
